// File: rtl/mem_bus_master.sv
// mem_bus_master: cache-side initiator on the A2/D2/C2 memory bus, one whole line per request.
// Optional response watchdog is compiled in when MEM_MASTER_TIMEOUT_EN is defined.
`ifndef ADDR2_BUS_SIZE
`define ADDR2_BUS_SIZE 10
`endif
`ifndef DATA2_BUS_BIT_SIZE
`define DATA2_BUS_BIT_SIZE 16
`endif
`ifndef CTR2_BUS_SIZE
`define CTR2_BUS_SIZE 2
`endif
`ifndef LINE_BYTE_SIZE
`define LINE_BYTE_SIZE 16
`endif
`ifndef BUS_CMD_NONE
`define BUS_CMD_NONE 0
`endif
`ifndef BUS_CMD_READ
`define BUS_CMD_READ 1
`endif
`ifndef BUS_CMD_WRITE
`define BUS_CMD_WRITE 2
`endif
`ifndef BUS_CMD_RESPONSE
`define BUS_CMD_RESPONSE 3
`endif

module mem_bus_master #(
    parameter int ADDR_W         = `ADDR2_BUS_SIZE,
    parameter int DATA_W         = `DATA2_BUS_BIT_SIZE,
    parameter int CTR_W          = `CTR2_BUS_SIZE,
    parameter int LINE_BYTES     = `LINE_BYTE_SIZE,
    parameter int BEATS          = LINE_BYTES * 8 / DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LINE_BYTES*8-1:0] req_wdata,
    output logic                    resp_valid,
    output logic [LINE_BYTES*8-1:0] resp_rdata,
    output logic                    resp_error,
    output logic [ADDR_W-1:0]       a2,
    inout  wire  [DATA_W-1:0]       d2,
    inout  wire  [CTR_W-1:0]        c2
);

    localparam int LINE_W = LINE_BYTES * 8;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [CTR_W-1:0] CMD_READ     = CTR_W'(`BUS_CMD_READ);
    localparam logic [CTR_W-1:0] CMD_WRITE    = CTR_W'(`BUS_CMD_WRITE);
    localparam logic [CTR_W-1:0] CMD_RESPONSE = CTR_W'(`BUS_CMD_RESPONSE);

    // A mis-sized instance (partial bytes per beat, zero watchdog) never accepts work.
    localparam bit CFG_OK = (DATA_W % 8 == 0) && (BEATS * DATA_W == LINE_W) && (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WBEAT, S_TURN, S_WAIT_RESP, S_RBEAT, S_DONE, S_ERR
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_next;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [LINE_W-1:0] wdata_q, rbuf_q, line_merged;
    logic [CNT_W-1:0]  cap_idx, drv_idx;
    logic              resp_seen, capture, tmo_hit, drive_c2, drive_d2;
    logic [DATA_W-1:0] d2_out;

    // Anything but RESPONSE (Z, X, NONE, READ, WRITE) leaves us waiting.
    assign resp_seen = (c2 == CMD_RESPONSE);

`ifdef MEM_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     tmo_cnt <= '0;
        else if (state != S_WAIT_RESP) tmo_cnt <= '0;
        else                           tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign resp_error = (state == S_ERR);
`else
    assign tmo_hit    = 1'b0;
    assign resp_error = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_cnt_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        unique case (state)
            S_IDLE: if (req_valid && req_ready) state_next = S_CMD;
            S_CMD: begin
                beat_cnt_next = CNT_W'(1);
                state_next    = (write_q && BEATS > 1) ? S_WBEAT : S_TURN;
            end
            S_WBEAT: begin
                if (beat_cnt == LAST_BEAT) state_next = S_TURN;
                else                       beat_cnt_next = beat_cnt + 1'b1;
            end
            S_TURN: state_next = S_WAIT_RESP;
            S_WAIT_RESP: begin
                if (resp_seen) begin
                    beat_cnt_next = CNT_W'(1);
                    state_next    = (write_q || BEATS == 1) ? S_DONE : S_RBEAT;
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            S_RBEAT: begin
                if (beat_cnt == LAST_BEAT) state_next = S_DONE;
                else                       beat_cnt_next = beat_cnt + 1'b1;
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign capture = ((state == S_WAIT_RESP) && resp_seen && !write_q) || (state == S_RBEAT);
    assign cap_idx = (state == S_RBEAT) ? beat_cnt : '0;

    always_comb begin
        line_merged = rbuf_q;
        line_merged[int'(cap_idx) * DATA_W +: DATA_W] = d2;
    end

    // NOTE: request/line buffers carry no reset; they are always written before the FSM reads them.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid && req_ready) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
        end
        if (capture) rbuf_q <= line_merged;
    end

    // The returned line only changes when a read completes, so it survives writes and timeouts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 resp_rdata <= '0;
        else if (capture && state_next == S_DONE)  resp_rdata <= line_merged;
    end

    assign req_ready  = (state == S_IDLE) && CFG_OK;
    assign resp_valid = (state == S_DONE);

    assign drive_c2 = (state == S_CMD);
    assign drive_d2 = ((state == S_CMD) && write_q) || (state == S_WBEAT);
    assign drv_idx  = (state == S_CMD) ? '0 : beat_cnt;
    assign d2_out   = wdata_q[int'(drv_idx) * DATA_W +: DATA_W];

    assign a2 = (state == S_CMD || state == S_WBEAT) ? addr_q : '0;
    assign c2 = drive_c2 ? (write_q ? CMD_WRITE : CMD_READ) : 'z;
    assign d2 = drive_d2 ? d2_out : 'z;

endmodule
